// File: rtl/dpram_pkg.sv
// Shared types and default sizes for the dual-port SRAM access controller.
package dpram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 64;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic                  err;
    logic [DATA_W_DEF-1:0] rdata;
  } rsp_t;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/dpram_access_ctrl_if.sv
// Client-side request/response bundle; master = client, slave = access controller.
interface dpram_access_ctrl_if
  import dpram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dpram_port_if.sv
// One SRAM port: range check, SRAM drive, single-stage read tracking and response.
module dpram_port_if
  import dpram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              in_range,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] wdata_hold_reg;
  logic              pend_reg;
  logic              err_reg;

  assign in_range = ({1'b0, addr} < DEPTH_LIM);

  // SRAM bus follows the accepted request, otherwise parks on the last one.
  assign ram_we    = accept & we & in_range;
  assign ram_addr  = accept ? addr  : addr_hold_reg;
  assign ram_wdata = accept ? wdata : wdata_hold_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
      pend_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      if (accept) begin
        addr_hold_reg  <= addr;
        wdata_hold_reg <= wdata;
      end
      pend_reg <= accept & ~we;
      err_reg  <= accept & ~we & ~in_range;
    end
  end

  // Out-of-range reads return zero data rather than whatever the macro produced.
  assign rsp_valid = pend_reg;
  assign rsp_err   = pend_reg & err_reg;
  assign rsp_rdata = (pend_reg & ~err_reg) ? ram_rdata : '0;

endmodule

// File: rtl/dpram_access_ctrl.sv
// Two-client front end for a dual-port SRAM with round-robin resolution of same-address conflicts.
module dpram_access_ctrl
  import dpram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  dpram_access_ctrl_if.slave   a,
  dpram_access_ctrl_if.slave   b,
  output logic                 ram_we_a,
  output logic [ADDR_W-1:0]    ram_addr_a,
  output logic [DATA_W-1:0]    ram_wdata_a,
  input  logic [DATA_W-1:0]    ram_rdata_a,
  output logic                 ram_we_b,
  output logic [ADDR_W-1:0]    ram_addr_b,
  output logic [DATA_W-1:0]    ram_wdata_b,
  input  logic [DATA_W-1:0]    ram_rdata_b,
  output logic [CNT_W-1:0]     coll_cnt
);

  logic [1:0]        valid;
  logic [1:0]        we;
  logic [1:0]        ready;
  logic [1:0]        accept;
  logic [1:0]        lose;
  logic [1:0]        in_range;
  logic [1:0]        ram_we;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_err;
  logic [ADDR_W-1:0] addr      [2];
  logic [DATA_W-1:0] wdata     [2];
  logic [ADDR_W-1:0] ram_addr  [2];
  logic [DATA_W-1:0] ram_wdata [2];
  logic [DATA_W-1:0] ram_rdata [2];
  logic [DATA_W-1:0] rsp_rdata [2];

  logic              collision;
  port_e             rr_prio_reg;
  port_e             rr_prio_next;
  logic [CNT_W-1:0]  coll_cnt_reg;
  logic [CNT_W-1:0]  coll_cnt_next;

  assign valid[0]     = a.req_valid;
  assign valid[1]     = b.req_valid;
  assign we[0]        = a.req_we;
  assign we[1]        = b.req_we;
  assign addr[0]      = a.req_addr;
  assign addr[1]      = b.req_addr;
  assign wdata[0]     = a.req_wdata;
  assign wdata[1]     = b.req_wdata;
  assign ram_rdata[0] = ram_rdata_a;
  assign ram_rdata[1] = ram_rdata_b;

  // Two reads of one word share it fine; only a write makes the pair conflict.
  assign collision = &valid & (addr[0] == addr[1]) & (|we) & (&in_range);

  assign lose[0] = collision & (rr_prio_reg == PORT_B);
  assign lose[1] = collision & (rr_prio_reg == PORT_A);
  assign ready   = valid & ~lose & {2{~rst}};
  assign accept  = valid & ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      dpram_port_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_port (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept[gi]),
        .we        (we[gi]),
        .addr      (addr[gi]),
        .wdata     (wdata[gi]),
        .in_range  (in_range[gi]),
        .ram_we    (ram_we[gi]),
        .ram_addr  (ram_addr[gi]),
        .ram_wdata (ram_wdata[gi]),
        .ram_rdata (ram_rdata[gi]),
        .rsp_valid (rsp_valid[gi]),
        .rsp_rdata (rsp_rdata[gi]),
        .rsp_err   (rsp_err[gi])
      );
    end
  endgenerate

  always_comb begin
    rr_prio_next  = rr_prio_reg;
    coll_cnt_next = coll_cnt_reg;
    if (collision) begin
      rr_prio_next = other_port(rr_prio_reg);
      if (coll_cnt_reg != {CNT_W{1'b1}}) begin
        coll_cnt_next = coll_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_prio_reg  <= PORT_A;
      coll_cnt_reg <= '0;
    end else begin
      rr_prio_reg  <= rr_prio_next;
      coll_cnt_reg <= coll_cnt_next;
    end
  end

  assign a.req_ready = ready[0];
  assign b.req_ready = ready[1];
  assign a.rsp_valid = rsp_valid[0];
  assign b.rsp_valid = rsp_valid[1];
  assign a.rsp_rdata = rsp_rdata[0];
  assign b.rsp_rdata = rsp_rdata[1];
  assign a.rsp_err   = rsp_err[0];
  assign b.rsp_err   = rsp_err[1];

  assign ram_we_a    = ram_we[0];
  assign ram_addr_a  = ram_addr[0];
  assign ram_wdata_a = ram_wdata[0];
  assign ram_we_b    = ram_we[1];
  assign ram_addr_b  = ram_addr[1];
  assign ram_wdata_b = ram_wdata[1];
  assign coll_cnt    = coll_cnt_reg;

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Bench for dpram_access_ctrl: directed scenarios plus random traffic against a word-level model.
module tb_dpram_access_ctrl;
  import dpram_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
  dpram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();
  dpram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ia2 ();
  dpram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ib2 ();

  logic          ram_we_a, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
  logic [15:0]   coll_cnt;

  logic          ram_we_a2, ram_we_b2;
  logic [AW-1:0] ram_addr_a2, ram_addr_b2;
  logic [DW-1:0] ram_wdata_a2, ram_wdata_b2;
  logic [DW-1:0] zero_rdata = '0;
  logic [1:0]    coll_cnt2;

  dpram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(ia), .b(ib),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_wdata_a(ram_wdata_a), .ram_rdata_a(ram_rdata_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_wdata_b(ram_wdata_b), .ram_rdata_b(ram_rdata_b),
    .coll_cnt(coll_cnt)
  );

  dpram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .a(ia2), .b(ib2),
    .ram_we_a(ram_we_a2), .ram_addr_a(ram_addr_a2), .ram_wdata_a(ram_wdata_a2), .ram_rdata_a(zero_rdata),
    .ram_we_b(ram_we_b2), .ram_addr_b(ram_addr_b2), .ram_wdata_b(ram_wdata_b2), .ram_rdata_b(zero_rdata),
    .coll_cnt(coll_cnt2)
  );

  // SRAM macro stand-in: registered read, one write per port per edge.
  logic [DW-1:0] sram [256];
  always @(posedge clk) begin
    if (ram_we_a) sram[ram_addr_a] <= ram_wdata_a;
    if (ram_we_b) sram[ram_addr_b] <= ram_wdata_b;
    ram_rdata_a <= sram[ram_addr_a];
    ram_rdata_b <= sram[ram_addr_b];
  end

  // Reference model: word store, arbitration turn, collision tally, next-cycle responses.
  logic [DW-1:0] m_mem [256];
  port_e         m_prio;
  int            m_cnt;
  logic          e_v [2];
  logic          e_e [2];
  logic [DW-1:0] e_d [2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_t r;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

  task automatic model_reset();
    m_prio = PORT_A;
    m_cnt  = 0;
    for (int i = 0; i < 2; i++) begin
      e_v[i] = 1'b0;
      e_e[i] = 1'b0;
      e_d[i] = '0;
    end
  endtask

  task automatic do_cycle(input logic av, input req_t ar, input logic bv, input req_t br);
    logic ain, bin, coll, xa, xb;
    @(negedge clk);
    ia.req_valid = av; ia.req_we = ar.we; ia.req_addr = ar.addr; ia.req_wdata = ar.wdata;
    ib.req_valid = bv; ib.req_we = br.we; ib.req_addr = br.addr; ib.req_wdata = br.wdata;
    #1;
    chk("a_rsp_valid", 32'(ia.rsp_valid), 32'(e_v[0]));
    chk("b_rsp_valid", 32'(ib.rsp_valid), 32'(e_v[1]));
    if (e_v[0]) begin
      chk("a_rsp_rdata", 32'(ia.rsp_rdata), 32'(e_d[0]));
      chk("a_rsp_err", 32'(ia.rsp_err), 32'(e_e[0]));
    end
    if (e_v[1]) begin
      chk("b_rsp_rdata", 32'(ib.rsp_rdata), 32'(e_d[1]));
      chk("b_rsp_err", 32'(ib.rsp_err), 32'(e_e[1]));
    end
    chk("coll_cnt", 32'(coll_cnt), 32'(m_cnt));

    ain  = 32'(ar.addr) < DEPTH;
    bin  = 32'(br.addr) < DEPTH;
    coll = av && bv && (ar.addr == br.addr) && (ar.we || br.we) && ain;
    xa   = av && !(coll && m_prio == PORT_B);
    xb   = bv && !(coll && m_prio == PORT_A);
    chk("a_req_ready", 32'(ia.req_ready), 32'(xa));
    chk("b_req_ready", 32'(ib.req_ready), 32'(xb));
    chk("ram_we_a", 32'(ram_we_a), 32'(xa && ar.we && ain));
    chk("ram_we_b", 32'(ram_we_b), 32'(xb && br.we && bin));
    if (xa) chk("ram_addr_a", 32'(ram_addr_a), 32'(ar.addr));
    if (xb) chk("ram_addr_b", 32'(ram_addr_b), 32'(br.addr));

    e_v[0] = xa && !ar.we;
    e_e[0] = !ain;
    e_d[0] = ain ? m_mem[ar.addr] : '0;
    e_v[1] = xb && !br.we;
    e_e[1] = !bin;
    e_d[1] = bin ? m_mem[br.addr] : '0;
    if (xa && ar.we && ain) m_mem[ar.addr] = ar.wdata;
    if (xb && br.we && bin) m_mem[br.addr] = br.wdata;
    if (coll) begin
      m_prio = (m_prio == PORT_A) ? PORT_B : PORT_A;
      m_cnt++;
    end
    $display("cyc %0d A v%0b we%0b @%0d d=%h acc=%0b | B v%0b we%0b @%0d d=%h acc=%0b | coll=%0b",
             cyc, av, ar.we, ar.addr, ar.wdata, xa, bv, br.we, br.addr, br.wdata, xb, coll);
    cyc++;
  endtask

  task automatic idle();
    do_cycle(1'b0, mk(1'b0, 8'd0, 16'd0), 1'b0, mk(1'b0, 8'd0, 16'd0));
  endtask

  initial begin
    req_t ra, rb;
    logic va, vb;
    ia.req_valid = 1'b0; ia.req_we = 1'b0; ia.req_addr = '0; ia.req_wdata = '0;
    ib.req_valid = 1'b0; ib.req_we = 1'b0; ib.req_addr = '0; ib.req_wdata = '0;
    ia2.req_valid = 1'b0; ia2.req_we = 1'b0; ia2.req_addr = '0; ia2.req_wdata = '0;
    ib2.req_valid = 1'b0; ib2.req_we = 1'b0; ib2.req_addr = '0; ib2.req_wdata = '0;
    model_reset();

    // Reset values, with a request presented while reset is held.
    repeat (2) @(negedge clk);
    ia.req_valid = 1'b1; ia.req_addr = 8'd5;
    #1;
    chk("rst_a_ready", 32'(ia.req_ready), 32'd0);
    chk("rst_a_rsp_valid", 32'(ia.rsp_valid), 32'd0);
    chk("rst_a_rsp_rdata", 32'(ia.rsp_rdata), 32'd0);
    chk("rst_ram_we_a", 32'(ram_we_a), 32'd0);
    chk("rst_ram_addr_a", 32'(ram_addr_a), 32'd0);
    chk("rst_coll_cnt", 32'(coll_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t1_a_ready", 32'(ia.req_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t1_a_rsp_valid", 32'(ia.rsp_valid), 32'd0);
    chk("t1_a_rsp_err", 32'(ia.rsp_err), 32'd0);
    chk("t1_ram_addr_a", 32'(ram_addr_a), 32'd0);
    chk("t1_ram_wdata_a", 32'(ram_wdata_a), 32'd0);
    chk("t1_coll_cnt", 32'(coll_cnt), 32'd0);
    @(negedge clk);
    ia.req_valid = 1'b0;
    rst = 1'b0;
    model_reset();

    // Give every in-range word a known value.
    for (int i = 0; i < 32; i++) begin
      do_cycle(1'b1, mk(1'b1, 8'(i), 16'($urandom)), 1'b1, mk(1'b1, 8'(i + 32), 16'($urandom)));
    end

    do_cycle(1'b1, mk(1'b1, 8'd3, 16'hBEEF), 1'b0, mk(1'b0, 8'd0, 16'd0));
    do_cycle(1'b1, mk(1'b0, 8'd3, 16'd0), 1'b0, mk(1'b0, 8'd0, 16'd0));
    idle();
    chk("t2_a_rdata", 32'(ia.rsp_rdata), 32'hBEEF);

    do_cycle(1'b1, mk(1'b1, 8'd10, 16'h1111), 1'b1, mk(1'b1, 8'd20, 16'h2222));
    do_cycle(1'b1, mk(1'b0, 8'd20, 16'd0), 1'b1, mk(1'b0, 8'd10, 16'd0));
    idle();
    chk("t3_a_rdata", 32'(ia.rsp_rdata), 32'h2222);
    chk("t3_b_rdata", 32'(ib.rsp_rdata), 32'h1111);

    do_cycle(1'b1, mk(1'b1, 8'd7, 16'hAAAA), 1'b1, mk(1'b1, 8'd7, 16'hBBBB));
    do_cycle(1'b1, mk(1'b1, 8'd7, 16'hAAAA), 1'b1, mk(1'b1, 8'd7, 16'hBBBB));
    do_cycle(1'b1, mk(1'b0, 8'd7, 16'd0), 1'b0, mk(1'b0, 8'd0, 16'd0));
    idle();
    chk("t4_a_rdata", 32'(ia.rsp_rdata), 32'hBBBB);
    chk("t4_coll_cnt", 32'(coll_cnt), 32'd2);

    do_cycle(1'b1, mk(1'b0, 8'd7, 16'd0), 1'b1, mk(1'b0, 8'd7, 16'd0));
    idle();
    chk("t5_a_rdata", 32'(ia.rsp_rdata), 32'hBBBB);
    chk("t5_b_rdata", 32'(ib.rsp_rdata), 32'hBBBB);
    chk("t5_coll_cnt", 32'(coll_cnt), 32'd2);

    do_cycle(1'b1, mk(1'b1, 8'd64, 16'h5555), 1'b0, mk(1'b0, 8'd0, 16'd0));
    do_cycle(1'b1, mk(1'b0, 8'd64, 16'd0), 1'b0, mk(1'b0, 8'd0, 16'd0));
    idle();
    chk("t6_a_rsp_valid", 32'(ia.rsp_valid), 32'd1);
    chk("t6_a_rdata", 32'(ia.rsp_rdata), 32'd0);
    chk("t6_a_err", 32'(ia.rsp_err), 32'd1);

    // Random traffic over a narrow address window so collisions are frequent.
    for (int n = 0; n < 300; n++) begin
      va = 1'($urandom_range(0, 3) != 0);
      vb = 1'($urandom_range(0, 3) != 0);
      ra = mk(1'($urandom), ($urandom_range(0, 7) == 0) ? 8'($urandom_range(60, 70)) : 8'($urandom_range(0, 9)), 16'($urandom));
      rb = mk(1'($urandom), ($urandom_range(0, 7) == 0) ? 8'($urandom_range(60, 70)) : 8'($urandom_range(0, 9)), 16'($urandom));
      do_cycle(va, ra, vb, rb);
    end
    idle();
    idle();

    // Saturation on the 2-bit counter instance.
    @(negedge clk);
    ia2.req_valid = 1'b1; ia2.req_we = 1'b1; ia2.req_addr = 8'd1; ia2.req_wdata = 16'h0A0A;
    ib2.req_valid = 1'b1; ib2.req_we = 1'b1; ib2.req_addr = 8'd1; ib2.req_wdata = 16'h0B0B;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
      chk("sat_coll_cnt", 32'(coll_cnt2), (n > 3) ? 32'd3 : 32'(n));
      $display("sat collision %0d coll_cnt=%0d", n, coll_cnt2);
    end
    @(negedge clk);
    ia2.req_valid = 1'b0;
    ib2.req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
